// File: rtl/mips_if_bpu_pkg.sv
// Shared constants and helpers for the IF-stage branch prediction unit.
package mips_if_bpu_pkg;

  localparam int MIPS_ADDR_WIDTH  = 32;
  localparam int MIPS_RFIDX_WIDTH = 5;
  localparam logic [MIPS_RFIDX_WIDTH-1:0] MIPS_RA_IDX = 5'd31;

  // 2-bit saturating counter encodings; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    MIPS_BHT_SNT = 2'b00,
    MIPS_BHT_WNT = 2'b01,
    MIPS_BHT_WT  = 2'b10,
    MIPS_BHT_ST  = 2'b11
  } bht_ctr_e;

  localparam bht_ctr_e MIPS_BHT_RST = MIPS_BHT_WNT;

  // Saturating step of a history counter towards the resolved outcome.
  function automatic bht_ctr_e bht_train(input bht_ctr_e ctr, input logic taken);
    bht_ctr_e res;
    res = ctr;
    case (ctr)
      MIPS_BHT_SNT: res = taken ? MIPS_BHT_WNT : MIPS_BHT_SNT;
      MIPS_BHT_WNT: res = taken ? MIPS_BHT_WT  : MIPS_BHT_SNT;
      MIPS_BHT_WT:  res = taken ? MIPS_BHT_ST  : MIPS_BHT_WNT;
      MIPS_BHT_ST:  res = taken ? MIPS_BHT_ST  : MIPS_BHT_WT;
      default:      res = ctr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_if_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; clear only drops the count, leaving pointer and contents alone.
module mips_if_ras
  import mips_if_bpu_pkg::*;
#(
  parameter int ADDR_WIDTH = MIPS_ADDR_WIDTH,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           replace,
  input  logic                           clear,
  input  logic [ADDR_WIDTH-1:0]          push_addr,
  output logic [ADDR_WIDTH-1:0]          top_addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] cnt
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] ent_reg [RAS_DEPTH];
  logic [PTR_W-1:0]      ptr_reg, ptr_next, ptr_inc, ptr_dec, wr_ptr;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  wr_en;

  // The pointer addresses the current top entry and wraps modulo depth.
  assign ptr_inc  = (ptr_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
  assign ptr_dec  = (ptr_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_reg - 1'b1;
  assign top_addr = ent_reg[ptr_reg];
  assign cnt      = cnt_reg;

  // Next pointer/count and write port; clear dominates any stack operation.
  always_comb begin
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    wr_en    = 1'b0;
    wr_ptr   = ptr_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (push) begin
      ptr_next = ptr_inc;
      wr_en    = 1'b1;
      wr_ptr   = ptr_inc;
      if (cnt_reg != CNT_W'(RAS_DEPTH)) cnt_next = cnt_reg + 1'b1;
    end else if (replace) begin
      wr_en = (cnt_reg != '0);
    end else if (pop && (cnt_reg != '0)) begin
      ptr_next = ptr_dec;
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
    end
  end

  // Entry storage; reset clears every slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) ent_reg[i] <= '0;
    end else if (wr_en) begin
      ent_reg[wr_ptr] <= push_addr;
    end
  end

endmodule

// File: rtl/mips_if_bpu.sv
// IF-stage branch prediction: BHT of 2-bit counters, RAS for returns,
// and the same-cycle next-PC prediction mux.
module mips_if_bpu
  import mips_if_bpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = MIPS_ADDR_WIDTH,
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4,
  parameter int DELAY_SLOT  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           if_valid,
  input  logic [ADDR_WIDTH-1:0]          pc,
  input  logic [ADDR_WIDTH-1:0]          pc_incr,
  input  logic                           dec_j,
  input  logic                           dec_jal,
  input  logic                           dec_jr,
  input  logic                           dec_jalr,
  input  logic                           dec_bxx,
  input  logic [MIPS_RFIDX_WIDTH-1:0]    dec_rs_idx,
  input  logic [ADDR_WIDTH-1:0]          dec_j_imm,
  input  logic [ADDR_WIDTH-1:0]          dec_b_imm,
  input  logic                           flush,
  input  logic                           ex_upd_vld,
  input  logic [ADDR_WIDTH-1:0]          ex_upd_pc,
  input  logic                           ex_upd_taken,
  output logic                           prdt_taken,
  output logic [ADDR_WIDTH-1:0]          prdt_pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_ctr_e              bht_reg [BHT_ENTRIES];
  logic [IDX_W-1:0]      rd_idx, upd_idx;
  bht_ctr_e              bht_rd;
  logic                  ret_cand, ras_en, ras_empty;
  logic                  ras_push, ras_pop, ras_replace;
  logic [ADDR_WIDTH-1:0] ret_addr, ras_top;
  logic                  unused_bits;

  assign rd_idx  = pc[IDX_W+1:2];
  assign upd_idx = ex_upd_pc[IDX_W+1:2];
  assign bht_rd  = bht_reg[rd_idx];

  // Word-offset and upper address bits never reach the table index.
  assign unused_bits = ^{pc[1:0], pc[ADDR_WIDTH-1:IDX_W+2],
                         ex_upd_pc[1:0], ex_upd_pc[ADDR_WIDTH-1:IDX_W+2]};

  assign ret_cand  = (dec_jr || dec_jalr) && (dec_rs_idx == MIPS_RA_IDX);
  assign ras_en    = if_valid && !flush;
  assign ras_empty = (ras_cnt == '0);
  assign ret_addr  = pc_incr + ADDR_WIDTH'(4 * DELAY_SLOT);

  // A return-candidate jalr links and returns at once: swap the top when
  // there is one, otherwise it degenerates to a plain push.
  assign ras_push    = ras_en && (dec_jal || (dec_jalr && (!ret_cand || ras_empty)));
  assign ras_pop     = ras_en && dec_jr && ret_cand;
  assign ras_replace = ras_en && dec_jalr && ret_cand && !ras_empty;

  mips_if_ras #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .replace   (ras_replace),
    .clear     (flush),
    .push_addr (ret_addr),
    .top_addr  (ras_top),
    .cnt       (ras_cnt)
  );

  // BHT training from EX; the fetch lookup reads the pre-update value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_reg[i] <= MIPS_BHT_RST;
    end else if (ex_upd_vld) begin
      bht_reg[upd_idx] <= bht_train(bht_reg[upd_idx], ex_upd_taken);
    end
  end

  // Next-PC prediction, first matching class wins.
  always_comb begin
    prdt_taken = 1'b0;
    prdt_pc    = pc_incr;
    if (if_valid) begin
      if (dec_j || dec_jal) begin
        prdt_taken = 1'b1;
        prdt_pc    = dec_j_imm;
      end else if (dec_bxx) begin
        if (bht_rd[1]) begin
          prdt_taken = 1'b1;
          prdt_pc    = dec_b_imm;
        end
      end else if (ret_cand && !ras_empty) begin
        prdt_taken = 1'b1;
        prdt_pc    = ras_top;
      end
    end
  end

endmodule

// File: tb/tb_mips_if_bpu.sv
// Directed bench for mips_if_bpu: stimulus queues expectations, a negedge
// monitor pops and compares them against the live prediction outputs.
module tb_mips_if_bpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] pc, pc_incr;
  logic        dec_j, dec_jal, dec_jr, dec_jalr, dec_bxx;
  logic [4:0]  dec_rs_idx;
  logic [31:0] dec_j_imm, dec_b_imm;
  logic        flush;
  logic        ex_upd_vld;
  logic [31:0] ex_upd_pc;
  logic        ex_upd_taken;
  logic        prdt_taken;
  logic [31:0] prdt_pc;
  logic [2:0]  ras_cnt;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  logic chk_en = 1'b0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  mips_if_bpu #(
    .ADDR_WIDTH  (32),
    .BHT_ENTRIES (64),
    .RAS_DEPTH   (4),
    .DELAY_SLOT  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .pc           (pc),
    .pc_incr      (pc_incr),
    .dec_j        (dec_j),
    .dec_jal      (dec_jal),
    .dec_jr       (dec_jr),
    .dec_jalr     (dec_jalr),
    .dec_bxx      (dec_bxx),
    .dec_rs_idx   (dec_rs_idx),
    .dec_j_imm    (dec_j_imm),
    .dec_b_imm    (dec_b_imm),
    .flush        (flush),
    .ex_upd_vld   (ex_upd_vld),
    .ex_upd_pc    (ex_upd_pc),
    .ex_upd_taken (ex_upd_taken),
    .prdt_taken   (prdt_taken),
    .prdt_pc      (prdt_pc),
    .ras_cnt      (ras_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: one comparison per checked cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: output present, got none expected");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (prdt_taken !== e.taken || prdt_pc !== e.pc || ras_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL %s: got taken=%0b pc=%h cnt=%0d, want taken=%0b pc=%h cnt=%0d",
                   e.name, prdt_taken, prdt_pc, ras_cnt, e.taken, e.pc, e.cnt);
        end else begin
          $display("ok   %s: taken=%0b pc=%h cnt=%0d", e.name, prdt_taken, prdt_pc, ras_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic clr();
    if_valid = 0; pc = 0; pc_incr = 0;
    dec_j = 0; dec_jal = 0; dec_jr = 0; dec_jalr = 0; dec_bxx = 0;
    dec_rs_idx = 0; dec_j_imm = 0; dec_b_imm = 0;
    flush = 0; ex_upd_vld = 0; ex_upd_pc = 0; ex_upd_taken = 0;
  endtask

  task automatic fetch(input logic [31:0] p);
    if_valid = 1; pc = p; pc_incr = p + 32'd4;
  endtask

  task automatic upd(input logic [31:0] p, input logic t);
    ex_upd_vld = 1; ex_upd_pc = p; ex_upd_taken = t;
  endtask

  // Hold the current inputs for one cycle, optionally queueing an expectation.
  task automatic step(input string nm, input bit chk, input logic et,
                      input logic [31:0] ep, input logic [2:0] ec);
    if (chk) sb.push_back('{nm, et, ep, ec});
    chk_en = chk;
    @(posedge clk); #1;
    chk_en = 0;
    clr();
  endtask

  initial begin
    logic [31:0] pops [4];
    pops[0] = 32'h68; pops[1] = 32'h58; pops[2] = 32'h48; pops[3] = 32'h38;
    clr();
    rst_n = 0;
    @(posedge clk); #1;
    pc_incr = 32'h104;
    step("reset_defaults", 1, 0, 32'h104, 0);
    rst_n = 1;

    // BHT training on 0x100
    fetch(32'h100); dec_bxx = 1; dec_b_imm = 32'h200;
    step("bxx_initial_wnt", 1, 0, 32'h104, 0);
    upd(32'h100, 1); step("", 0, 0, 0, 0);
    upd(32'h100, 1); step("", 0, 0, 0, 0);
    fetch(32'h100); dec_bxx = 1; dec_b_imm = 32'h200;
    step("bxx_after_2_taken", 1, 1, 32'h200, 0);
    upd(32'h100, 0); step("", 0, 0, 0, 0);
    fetch(32'h100); dec_bxx = 1; dec_b_imm = 32'h200;
    step("bxx_weak_taken", 1, 1, 32'h200, 0);
    upd(32'h100, 0); step("", 0, 0, 0, 0);
    upd(32'h100, 0); step("", 0, 0, 0, 0);
    fetch(32'h100); dec_bxx = 1; dec_b_imm = 32'h200;
    step("bxx_after_3_not_taken", 1, 0, 32'h104, 0);

    // jal / jr return
    fetch(32'h400); dec_jal = 1; dec_j_imm = 32'h1000;
    step("jal_0x400", 1, 1, 32'h1000, 0);
    fetch(32'h1000); dec_jr = 1; dec_rs_idx = 31;
    step("jr_ret_0x408", 1, 1, 32'h408, 1);
    fetch(32'h1000); dec_jr = 1; dec_rs_idx = 31;
    step("jr_empty", 1, 0, 32'h1004, 0);

    // overflow: six pushes into a depth-4 stack
    for (int i = 1; i <= 6; i++) begin
      fetch(32'(i * 16)); dec_jal = 1; dec_j_imm = 32'h800;
      step($sformatf("jal_fill_%0d", i), 1, 1, 32'h800, 3'((i - 1 > 4) ? 4 : i - 1));
    end
    for (int i = 0; i < 4; i++) begin
      fetch(32'h800); dec_jr = 1; dec_rs_idx = 31;
      step($sformatf("pop_%0d", i), 1, 1, pops[i], 3'(4 - i));
    end
    fetch(32'h800); dec_jr = 1; dec_rs_idx = 31;
    step("pop_empty", 1, 0, 32'h804, 0);

    // jalr replace / push and non-ra jr
    fetch(32'h40); dec_jal = 1; dec_j_imm = 32'h900;
    step("jal_0x40", 1, 1, 32'h900, 0);
    fetch(32'h100); dec_jalr = 1; dec_rs_idx = 31;
    step("jalr_ra_replace", 1, 1, 32'h48, 1);
    fetch(32'h200); dec_jr = 1; dec_rs_idx = 5;
    step("jr_rs5_not_taken", 1, 0, 32'h204, 1);
    fetch(32'h300); dec_jr = 1; dec_rs_idx = 31;
    step("jr_after_replace", 1, 1, 32'h108, 1);
    fetch(32'h500); dec_jalr = 1; dec_rs_idx = 4;
    step("jalr_rs4_push", 1, 0, 32'h504, 0);
    fetch(32'h600); dec_jalr = 1; dec_rs_idx = 31;
    step("jalr_ra_swap", 1, 1, 32'h508, 1);
    fetch(32'h700); dec_jr = 1; dec_rs_idx = 31;
    step("jr_after_swap", 1, 1, 32'h608, 1);

    // flush beats push
    fetch(32'h700); dec_jal = 1; dec_j_imm = 32'hA00;
    step("jal_0x700", 1, 1, 32'hA00, 0);
    fetch(32'h720); dec_jal = 1; dec_j_imm = 32'hB00; flush = 1;
    step("jal_with_flush", 1, 1, 32'hB00, 1);
    fetch(32'h740); dec_jr = 1; dec_rs_idx = 31;
    step("jr_after_flush", 1, 0, 32'h744, 0);

    // read-before-write on the same index
    fetch(32'h104); dec_bxx = 1; dec_b_imm = 32'h500; upd(32'h104, 1);
    step("bxx_same_cycle_train", 1, 0, 32'h108, 0);
    fetch(32'h104); dec_bxx = 1; dec_b_imm = 32'h500;
    step("bxx_next_cycle", 1, 1, 32'h500, 0);

    // reset mid-operation
    upd(32'h104, 1); step("", 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      fetch(32'(i * 16)); dec_jal = 1; dec_j_imm = 32'h800;
      step($sformatf("jal_pre_reset_%0d", i), 1, 1, 32'h800, 3'(i - 1));
    end
    fetch(32'h104); dec_bxx = 1; dec_b_imm = 32'h500;
    step("bxx_strong_taken", 1, 1, 32'h500, 3);
    rst_n = 0;
    fetch(32'h50); dec_jal = 1; dec_j_imm = 32'h800; upd(32'h104, 1);
    step("jal_at_reset_edge", 1, 1, 32'h800, 3);
    rst_n = 0;
    fetch(32'h50); dec_jal = 1; dec_j_imm = 32'h800; upd(32'h104, 1);
    step("jal_reset_held", 1, 1, 32'h800, 0);
    rst_n = 1;
    fetch(32'h104); dec_bxx = 1; dec_b_imm = 32'h500;
    step("bxx_after_reset", 1, 0, 32'h108, 0);
    fetch(32'h104); dec_jr = 1; dec_rs_idx = 31;
    step("jr_after_reset", 1, 0, 32'h108, 0);

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_if_bpu.md
# mips_if_bpu

Instruction-fetch branch prediction unit with parametrised history table and return-address stack. Consumes the fetch-stage mini-decoder's BJP flags and targets, and produces a same-cycle next-PC prediction. A 2-bit-counter branch history table (BHT) is trained by EX-stage branch resolution. A circular return-address stack (RAS) predicts `jr $31` and `jalr` returns. It sits between the IF mini-decoder and the PC-select mux.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: PC/target width.
- `BHT_ENTRIES`, default 64: BHT size; power of two, ≥ 2.
- `RAS_DEPTH`, default 4: RAS entries, ≥ 1.
- `DELAY_SLOT`, default 1: 1 means the return address is pc_incr+4; 0 means the return address is pc_incr.

Ports:
- Clock and reset:
  - `clk` in 1: sole clock.
  - `rst_n` in 1: synchronous, active-low reset.
- Fetch slot:
  - `if_valid` in 1: fetch slot holds a valid instruction and advances this cycle.
  - `pc` in ADDR_WIDTH: fetched instruction address.
  - `pc_incr` in ADDR_WIDTH: pc+4.
- Mini-decoder flags and fields:
  - `dec_j`, `dec_jal`, `dec_jr`, `dec_jalr`, `dec_bxx` in 1 each: mini-decoder class flags, mutually exclusive.
  - `dec_rs_idx` in `MIPS_RFIDX_WIDTH`: rs field.
  - `dec_j_imm`, `dec_b_imm` in ADDR_WIDTH: absolute jump and branch targets.
- Flush and training:
  - `flush` in 1: pipeline flush (mispredict or exception).
  - `ex_upd_vld` in 1: EX resolved a conditional branch.
  - `ex_upd_pc` in ADDR_WIDTH: resolved branch address.
  - `ex_upd_taken` in 1: actual outcome.
- Outputs:
  - `prdt_taken` out 1: predict redirect.
  - `prdt_pc` out ADDR_WIDTH: predicted next PC.
  - `ras_cnt` out clog2(RAS_DEPTH+1): valid RAS entries.

## Operation
- BHT index is `pc[clog2(BHT_ENTRIES)+1:2]`. Each entry is a 2-bit saturating counter: 00 = strong NT, 01 = weak NT, 10 = weak T, 11 = strong T.
- A return candidate is `dec_jr` or `dec_jalr` with `dec_rs_idx`==31.
- The prediction is combinational and evaluated only when `if_valid`. Priority, first match wins:
  - `dec_j` or `dec_jal`: taken, target `dec_j_imm`.
  - `dec_bxx`: taken iff counter[1]=1, target `dec_b_imm`.
  - Return candidate with `ras_cnt`>0: taken, target RAS top.
  - Otherwise, including `dec_jr`/`dec_jalr` with rs≠31 or an empty RAS: not taken.
- When not taken, `prdt_pc` = `pc_incr`, and `prdt_taken`=0.
- RAS updates occur on `if_valid` & !`flush`. Return address = `pc_incr` + 4·DELAY_SLOT, truncated to ADDR_WIDTH.
  - `dec_jal`, or `dec_jalr` with rs≠31: push.
  - `dec_jr` return candidate: pop; no effect if empty.
  - `dec_jalr` return candidate with nonempty RAS: top entry replaced by the new return address; count unchanged.
  - `dec_jalr` return candidate with empty RAS: push.
- RAS overflow: the buffer is circular. A push when full overwrites the oldest entry, the top pointer wraps modulo RAS_DEPTH, and `ras_cnt` saturates at RAS_DEPTH.
- `flush` sets `ras_cnt` to 0. RAS entry contents are retained but unused. The top pointer is unchanged.
- BHT training: on `ex_upd_vld`, the counter at the index of `ex_upd_pc` increments (taken) or decrements (not taken), saturating at 11 and 00. Training is independent of `flush` and `if_valid`.

## Timing
- Prediction latency is 0 cycles: `prdt_*` are combinational from the inputs and registered state.
- State (BHT, RAS, `ras_cnt`) changes only at the rising `clk` edge.
- Same-index lookup and training in one cycle: the lookup sees the pre-update counter (read-before-write).
- `flush` and a push/pop in the same cycle: flush wins; `ras_cnt`=0 next cycle and no push is performed.
- Reset is synchronous on `rst_n`=0 at the clock edge:
  - All BHT counters are set to 01.
  - `ras_cnt`=0 and the top pointer is 0.
  - RAS entries are set to 0.
  - While reset is held, state does not change regardless of other inputs.
  - Reset asserted mid-operation discards all history at that edge.
- Output reset values:
  - `ras_cnt`=0.
  - `prdt_taken`=0 when no flag is set.
  - `prdt_pc`=`pc_incr` when no flag is set.

## Structure
- The shared defines file holds:
  - `MIPS_ADDR_WIDTH`, `MIPS_RFIDX_WIDTH`.
  - `MIPS_RA_IDX` (31).
  - Counter encodings `MIPS_BHT_SNT`/`WNT`/`WT`/`ST`.
  - BHT reset value `MIPS_BHT_RST` (01).
- Sub-module `mips_if_ras`: circular stack with push/pop/replace/clear inputs and top/count outputs, parametrised by ADDR_WIDTH and RAS_DEPTH.
- The BHT and prediction mux live in `mips_if_bpu`.

## Test plan
- Reset, then `dec_bxx` at pc 0x100 with `dec_b_imm`=0x200 → `prdt_taken`=0, `prdt_pc`=0x104. Then two `ex_upd_taken` updates at 0x100 → the same fetch gives `prdt_taken`=1, `prdt_pc`=0x200. Then three not-taken updates → not taken again.
- `dec_jal` at 0x400 (DELAY_SLOT=1), then `dec_jr` rs=31 → `prdt_pc`=0x408 and `ras_cnt` returns 1→0. A further `dec_jr` rs=31 → not taken, `prdt_pc`=pc_incr.
- RAS_DEPTH=4: six `jal` at 0x10, 0x20, …, 0x60, then five pops → returns 0x68, 0x58, 0x48, 0x38 (`ras_cnt` stays saturated at 4 until the pops begin, then reaches 0), and the fifth pop is not taken.
- `jal` in the same cycle as `flush` → `ras_cnt`=0. A following `jr $31` → not taken.
- Training and lookup on the same index in the same cycle, counter at 01 with a taken update → `prdt_taken`=0 that cycle, and 1 on a lookup of that index the next cycle.
- Reset asserted while `ras_cnt`=3 and counters are at 11 → next cycle `ras_cnt`=0, and branches predict not taken.
